// File: rtl/core_pkg.sv
// Shared core definitions: hazard FSM state encoding and architectural constants.
package core_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      REDIRECT = 2'd2
   } hazard_state_e;

   // x0 is hard-wired zero, so it never creates a true dependency
   localparam logic [4:0] REG_X0 = 5'd0;

   localparam int unsigned PERF_W = 32;

endpackage

// File: rtl/hazard_perf_counters.sv
// Bank of saturating event counters; each lane counts cycles its increment is high.
module hazard_perf_counters
   import core_pkg::*;
#(
   parameter int unsigned N = 3
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [N-1:0]               inc_i,
   output logic [N-1:0][PERF_W-1:0]   cnt_o
);

   logic [N-1:0][PERF_W-1:0] cnt_q, cnt_d;

   // Next count: hold at all-ones once saturated
   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < int'(N); i++) begin
         if (inc_i[i] && (cnt_q[i] != {PERF_W{1'b1}})) cnt_d[i] = cnt_q[i] + 1'b1;
      end
   end

   // Counter registers, cleared by reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline stall/flush sequencer for the 5-stage core.
// Optional build macro HAZARD_PERF_CNT_EN adds three 32-bit saturating event counters.
module hazard_controller
   import core_pkg::*;
#(
   parameter int unsigned REDIRECT_BUBBLES = 1   // 0..7
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic [4:0] ex_rd,
   input  logic       ex_mem_read,
   input  logic       ex_reg_write,
   input  logic       ex_redirect,
   input  logic       dmem_req,
   input  logic       dmem_ready,
   output logic       pc_en,
   output logic       if_id_en,
   output logic       if_id_flush,
   output logic       id_ex_en,
   output logic       id_ex_flush,
   output logic       ex_mem_en,
   output logic       mem_wb_bubble,
   output logic [1:0] state_o
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] perf_load_use_cnt,
   output logic [31:0] perf_mem_wait_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   hazard_state_e state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          mem_stall, load_use;
   logic          lu_act, mw_act;

   assign mem_stall = dmem_req & ~dmem_ready;
   assign load_use  = ex_mem_read & ex_reg_write & (ex_rd != REG_X0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

   // Next state and stage controls; priority mem_stall > ex_redirect > load_use
   always_comb begin
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_en      = 1'b1;
      id_ex_flush   = 1'b0;
      ex_mem_en     = 1'b1;
      mem_wb_bubble = 1'b0;
      lu_act        = 1'b0;
      mw_act        = 1'b0;
      state_d       = state_q;
      cnt_d         = cnt_q;

      if (mem_stall) begin
         // Freeze everything up to EX; a redirect in EX is re-presented later.
         // The bubble counter is held so an interrupted redirect resumes.
         pc_en         = 1'b0;
         if_id_en      = 1'b0;
         id_ex_en      = 1'b0;
         ex_mem_en     = 1'b0;
         mem_wb_bubble = 1'b1;
         mw_act        = 1'b1;
         state_d       = MEM_WAIT;
      end else if (ex_redirect) begin
         // ID holds a wrong-path instruction, so any load-use there is moot
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         cnt_d       = 3'(REDIRECT_BUBBLES);
         state_d     = (REDIRECT_BUBBLES > 0) ? REDIRECT : RUN;
      end else begin
         unique case (state_q)
            REDIRECT: begin
               if_id_flush = 1'b1;
               cnt_d       = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;
               state_d     = (cnt_q <= 3'd1) ? RUN : REDIRECT;
            end
            default: begin
               // RUN, the release cycle of MEM_WAIT, and the unused encoding.
               // A nonzero counter means the stall interrupted a redirect.
               state_d = ((state_q == MEM_WAIT) && (cnt_q != 3'd0)) ? REDIRECT : RUN;
               if (load_use) begin
                  pc_en       = 1'b0;
                  if_id_en    = 1'b0;
                  id_ex_flush = 1'b1;
                  lu_act      = 1'b1;
               end
            end
         endcase
      end

      // Reset forces safe controls immediately, independent of the clock
      if (!rstn) begin
         pc_en         = 1'b0;
         if_id_en      = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_en      = 1'b0;
         id_ex_flush   = 1'b1;
         ex_mem_en     = 1'b0;
         mem_wb_bubble = 1'b1;
         lu_act        = 1'b0;
         mw_act        = 1'b0;
      end
   end

   // FSM state and redirect bubble counter
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= RUN;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [2:0][PERF_W-1:0] perf_cnt;

   hazard_perf_counters #(.N(3)) u_perf (
      .clk   (clk),
      .rstn  (rstn),
      .inc_i ({if_id_flush & rstn, mw_act, lu_act}),
      .cnt_o (perf_cnt)
   );

   assign perf_load_use_cnt = perf_cnt[0];
   assign perf_mem_wait_cnt = perf_cnt[1];
   assign perf_flush_cnt    = perf_cnt[2];
`endif

endmodule
